// File: rtl/sound_latch_ctrl.sv
// ---------------------------------------------------------------------------
// sound_latch_ctrl
//   One-byte mailbox from the 68k main CPU to the Z80 sound CPU. It tracks
//   whether the byte has been read, flags overrun and signals the Z80 by
//   INT or NMI.
//
// Ports
//   clk, reset        single clock; synchronous active-high reset
//   m68k_latch_cs     68k latch write select (level; acts once per assertion)
//   m68k_sound_cs     68k status read select (not needed: status is
//                     registered every cycle)
//   m68k_din[7:0]     68k data bus low byte
//   m68k_dout[15:0]   status word {14'b0, overrun, latch not empty}
//   z80_latch_cs      Z80 latch select
//   RD_n, WR_n        Z80 strobes: read = take byte, write = clear latch
//   IORQ_n, M1_n      Z80 cycle type; both low = interrupt acknowledge
//   opl_irq_n         YM3812 interrupt, active low
//   z80_dout[7:0]     latch byte, or IRQ_VECTOR during interrupt acknowledge
//   z80_int_n         Z80 maskable interrupt, active low
//   z80_nmi_n         Z80 NMI, active low (NMI_MODE=1 only)
// ---------------------------------------------------------------------------
module sound_latch_ctrl #(
    parameter logic [7:0] IRQ_VECTOR = 8'hFF,
    parameter int         NMI_MODE   = 0,
    parameter int         NMI_WIDTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m68k_latch_cs,
    input  logic        m68k_sound_cs,
    input  logic [7:0]  m68k_din,
    output logic [15:0] m68k_dout,
    input  logic        z80_latch_cs,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        IORQ_n,
    input  logic        M1_n,
    input  logic        opl_irq_n,
    output logic [7:0]  z80_dout,
    output logic        z80_int_n,
    output logic        z80_nmi_n
);

    localparam logic [3:0] NMI_LOAD = 4'(NMI_WIDTH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // The status word is registered every cycle, so the read select is
    // not needed.
    logic unused_sound_cs;
    assign unused_sound_cs = m68k_sound_cs;

    // Strobe vector: bit0 = 68k write, bit1 = Z80 read, bit2 = Z80 clear
    logic [2:0] strb;
    logic [2:0] strb_prev_q;
    logic [2:0] rst_hold_q;
    logic [2:0] strb_edge;
    logic       wr_edge, rd_edge, clr_edge;

    assign strb = {z80_latch_cs & ~WR_n, z80_latch_cs & ~RD_n, m68k_latch_cs};

    // rst_hold_q remembers strobes that were high during the last reset
    // cycle, so a strobe held through reset release is not seen as a new
    // access on the first cycle after release.
    assign strb_edge = strb & ~strb_prev_q & ~rst_hold_q;
    assign wr_edge   = strb_edge[0];
    assign rd_edge   = strb_edge[1];
    assign clr_edge  = strb_edge[2];

    state_t      state_q, state_d;
    logic [7:0]  latch_q, latch_d;
    logic        overrun_q, overrun_d;
    logic        int_n_q, int_n_d;
    logic        nmi_n_q, nmi_n_d;
    logic [3:0]  nmi_cnt_q, nmi_cnt_d;
    logic [15:0] m68k_dout_q, m68k_dout_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            latch_q     <= 8'h00;
            overrun_q   <= 1'b0;
            int_n_q     <= 1'b1;
            nmi_n_q     <= 1'b1;
            nmi_cnt_q   <= 4'd0;
            m68k_dout_q <= 16'h0000;
            strb_prev_q <= 3'b000;
            rst_hold_q  <= strb;
        end else begin
            state_q     <= state_d;
            latch_q     <= latch_d;
            overrun_q   <= overrun_d;
            int_n_q     <= int_n_d;
            nmi_n_q     <= nmi_n_d;
            nmi_cnt_q   <= nmi_cnt_d;
            m68k_dout_q <= m68k_dout_d;
            strb_prev_q <= strb;
            rst_hold_q  <= 3'b000;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        latch_d   = latch_q;
        overrun_d = overrun_q;
        if (wr_edge) begin
            // A 68k write beats a same-cycle Z80 clear; in that case the
            // overrun flag is left as it was.
            state_d = ST_FULL;
            latch_d = m68k_din;
            if (!clr_edge && state_q == ST_FULL) begin
                overrun_d = 1'b1;
            end
        end else if (clr_edge) begin
            // Clear empties the mailbox but keeps the byte on z80_dout.
            state_d   = ST_EMPTY;
            overrun_d = 1'b0;
        end else if (rd_edge && state_q == ST_FULL) begin
            state_d = ST_READ;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        m68k_dout_d = {14'b0, overrun_q, state_q != ST_EMPTY};
        int_n_d     = opl_irq_n;
        nmi_cnt_d   = 4'd0;
        if (NMI_MODE == 0) begin
            int_n_d = opl_irq_n & (state_q != ST_FULL);
        end else if (wr_edge) begin
            // A write during a pulse reloads the counter and stretches it.
            nmi_cnt_d = NMI_LOAD;
        end else if (nmi_cnt_q != 4'd0) begin
            nmi_cnt_d = nmi_cnt_q - 4'd1;
        end
        // Registered from the next count so the pulse starts in the cycle
        // right after the write edge and is free of decode glitches.
        nmi_n_d  = (nmi_cnt_d == 4'd0);
        z80_dout = (!M1_n && !IORQ_n) ? IRQ_VECTOR : latch_q;
    end

    assign m68k_dout = m68k_dout_q;
    assign z80_int_n = int_n_q;
    assign z80_nmi_n = nmi_n_q;

endmodule

// File: tb/tb_sound_latch_ctrl.sv
module tb_sound_latch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m68k_latch_cs = 1'b0;
    logic        m68k_sound_cs = 1'b0;
    logic [7:0]  m68k_din = 8'h00;
    logic        z80_latch_cs = 1'b0;
    logic        RD_n = 1'b1;
    logic        WR_n = 1'b1;
    logic        IORQ_n = 1'b1;
    logic        M1_n = 1'b1;
    logic        opl_irq_n = 1'b1;

    logic [15:0] m68k_dout0, m68k_dout1;
    logic [7:0]  z80_dout0, z80_dout1;
    logic        int_n0, int_n1, nmi_n0, nmi_n1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Latch-full drives INT
    sound_latch_ctrl #(.IRQ_VECTOR(8'hFF), .NMI_MODE(0), .NMI_WIDTH(4)) u_dut0 (
        .clk(clk), .reset(reset),
        .m68k_latch_cs(m68k_latch_cs), .m68k_sound_cs(m68k_sound_cs),
        .m68k_din(m68k_din), .m68k_dout(m68k_dout0),
        .z80_latch_cs(z80_latch_cs), .RD_n(RD_n), .WR_n(WR_n),
        .IORQ_n(IORQ_n), .M1_n(M1_n), .opl_irq_n(opl_irq_n),
        .z80_dout(z80_dout0), .z80_int_n(int_n0), .z80_nmi_n(nmi_n0)
    );

    // Latch write pulses NMI
    sound_latch_ctrl #(.IRQ_VECTOR(8'hFF), .NMI_MODE(1), .NMI_WIDTH(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .m68k_latch_cs(m68k_latch_cs), .m68k_sound_cs(m68k_sound_cs),
        .m68k_din(m68k_din), .m68k_dout(m68k_dout1),
        .z80_latch_cs(z80_latch_cs), .RD_n(RD_n), .WR_n(WR_n),
        .IORQ_n(IORQ_n), .M1_n(M1_n), .opl_irq_n(opl_irq_n),
        .z80_dout(z80_dout1), .z80_int_n(int_n1), .z80_nmi_n(nmi_n1)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic z80_clear;
        z80_latch_cs = 1'b1; WR_n = 1'b0;
        tick();
        z80_latch_cs = 1'b0; WR_n = 1'b1;
        tick();
    endtask

    int lows;

    initial begin
        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_m68k_dout", m68k_dout0, 16'h0000);
        chk("rst_int_n", {15'b0, int_n0}, 16'h0001);
        chk("rst_nmi_n", {15'b0, nmi_n1}, 16'h0001);
        chk("rst_z80_dout", {8'b0, z80_dout0}, 16'h0000);
        reset = 1'b0;
        tick();

        // ---------------- basic handshake ----------------
        m68k_din = 8'h5A; m68k_latch_cs = 1'b1;
        tick();
        chk("hs_int_n_latency", {15'b0, int_n0}, 16'h0001);
        chk("hs_capture", {8'b0, z80_dout0}, 16'h005A);
        tick();
        chk("hs_int_n_low", {15'b0, int_n0}, 16'h0000);
        chk("hs_status_full", m68k_dout0, 16'h0001);
        chk("hs_mode1_int_n", {15'b0, int_n1}, 16'h0001);
        tick();
        m68k_latch_cs = 1'b0;
        tick();
        chk("hs_held_no_overrun", m68k_dout0, 16'h0001);
        z80_latch_cs = 1'b1; RD_n = 1'b0;
        tick();
        chk("hs_read_data", {8'b0, z80_dout0}, 16'h005A);
        tick();
        z80_latch_cs = 1'b0; RD_n = 1'b1;
        chk("hs_read_int_n", {15'b0, int_n0}, 16'h0001);
        chk("hs_read_status", m68k_dout0, 16'h0001);
        z80_clear();
        chk("hs_clear_status", m68k_dout0, 16'h0000);
        chk("hs_clear_keeps_data", {8'b0, z80_dout0}, 16'h005A);
        chk("hs_mode0_nmi_n", {15'b0, nmi_n0}, 16'h0001);

        // ---------------- overrun ----------------
        m68k_din = 8'h11; m68k_latch_cs = 1'b1; tick();
        m68k_latch_cs = 1'b0; tick();
        m68k_din = 8'h22; m68k_latch_cs = 1'b1; tick();
        m68k_latch_cs = 1'b0; tick();
        chk("ovr_data", {8'b0, z80_dout0}, 16'h0022);
        chk("ovr_status", m68k_dout0, 16'h0003);
        z80_clear();
        chk("ovr_clear_status", m68k_dout0, 16'h0000);

        // ---------------- simultaneous write and clear ----------------
        m68k_din = 8'h33; m68k_latch_cs = 1'b1;
        z80_latch_cs = 1'b1; WR_n = 1'b0;
        tick();
        m68k_latch_cs = 1'b0; z80_latch_cs = 1'b0; WR_n = 1'b1;
        tick();
        chk("sim_status", m68k_dout0, 16'h0001);
        chk("sim_data", {8'b0, z80_dout0}, 16'h0033);
        chk("sim_int_n", {15'b0, int_n0}, 16'h0000);
        z80_clear();

        // ---------------- interrupt acknowledge / OPL irq ----------------
        M1_n = 1'b0; IORQ_n = 1'b0; #1;
        chk("iack_vector", {8'b0, z80_dout0}, 16'h00FF);
        M1_n = 1'b1; IORQ_n = 1'b1; #1;
        chk("iack_release", {8'b0, z80_dout0}, 16'h0033);
        chk("opl_idle_int_n", {15'b0, int_n0}, 16'h0001);
        opl_irq_n = 1'b0;
        tick();
        chk("opl_int_n", {15'b0, int_n0}, 16'h0000);
        chk("opl_int_n_mode1", {15'b0, int_n1}, 16'h0000);
        opl_irq_n = 1'b1;
        tick();
        chk("opl_release", {15'b0, int_n0}, 16'h0001);

        // ---------------- NMI pulse ----------------
        tick(); tick();
        chk("nmi_idle", {15'b0, nmi_n1}, 16'h0001);
        m68k_din = 8'h44; m68k_latch_cs = 1'b1; tick();
        m68k_latch_cs = 1'b0;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("nmi_single_c%0d", i), {15'b0, nmi_n1}, (i < 4) ? 16'h0000 : 16'h0001);
            if (nmi_n1 == 1'b0) lows++;
            chk($sformatf("nmi_mode0_c%0d", i), {15'b0, nmi_n0}, 16'h0001);
            tick();
        end
        chk("nmi_single_len", 16'(lows), 16'd4);

        m68k_din = 8'h55; m68k_latch_cs = 1'b1; tick();
        m68k_latch_cs = 1'b0;
        lows = 0;
        chk("nmi_ext_c0", {15'b0, nmi_n1}, 16'h0000);
        if (nmi_n1 == 1'b0) lows++;
        tick();
        chk("nmi_ext_c1", {15'b0, nmi_n1}, 16'h0000);
        if (nmi_n1 == 1'b0) lows++;
        m68k_latch_cs = 1'b1; tick();
        m68k_latch_cs = 1'b0;
        for (int i = 2; i < 8; i++) begin
            chk($sformatf("nmi_ext_c%0d", i), {15'b0, nmi_n1}, (i < 6) ? 16'h0000 : 16'h0001);
            if (nmi_n1 == 1'b0) lows++;
            tick();
        end
        chk("nmi_ext_len", 16'(lows), 16'd6);

        // ---------------- reset while full with overrun ----------------
        m68k_din = 8'hAA; m68k_latch_cs = 1'b1; tick();
        m68k_latch_cs = 1'b0; tick();
        m68k_din = 8'hBB; m68k_latch_cs = 1'b1; tick();
        m68k_din = 8'hCC; tick();
        chk("rf_pre_status", m68k_dout0, 16'h0003);
        reset = 1'b1;
        tick();
        chk("rf_status", m68k_dout0, 16'h0000);
        chk("rf_int_n", {15'b0, int_n0}, 16'h0001);
        chk("rf_nmi_n", {15'b0, nmi_n1}, 16'h0001);
        chk("rf_data", {8'b0, z80_dout0}, 16'h0000);
        chk("rf_status_mode1", m68k_dout1, 16'h0000);
        reset = 1'b0;
        tick();
        chk("rf_held_no_capture", {8'b0, z80_dout0}, 16'h0000);
        tick();
        chk("rf_held_status", m68k_dout0, 16'h0000);
        chk("rf_held_no_nmi", {15'b0, nmi_n1}, 16'h0001);
        m68k_latch_cs = 1'b0; tick();
        m68k_latch_cs = 1'b1; tick();
        chk("rf_recapture", {8'b0, z80_dout0}, 16'h00CC);
        m68k_latch_cs = 1'b0; tick();
        chk("rf_recapture_status", m68k_dout0, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
